wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter for the RV core: merges single-cycle ALU results and long-latency memory/load results into the single write port of the register set (`write`, `write_reg`, `write_enable`). It buffers memory results in a small FIFO and tracks outstanding load destinations in a busy scoreboard. Issue logic uses the scoreboard to stall on RAW hazards.

## Interface
Parameters:
- `RegisterCount`, `REGISTER_COUNT` (32): number of architectural registers; x0 is hardwired zero.
- `FifoDepth`, 2: memory-result buffer entries, power of two, ≥2.
- `StarveLimit`, 4: consecutive cycles a non-empty FIFO may lose to the ALU before it is forced through.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `res`  in  1  reset, asynchronous, active-low.
- `alu_valid`  in  1  ALU result present this cycle; always accepted, no backpressure.
- `alu_rd`  in  `regnum`  ALU destination.
- `alu_data`  in  `word`  ALU result.
- `alu_stall`  out  1  registered; upstream must not assert `alu_valid` while high.
- `mem_valid`  in  1  memory result offered.
- `mem_ready`  out  1  FIFO can accept; transfer when `mem_valid && mem_ready`.
- `mem_rd`  in  `regnum`  load destination.
- `mem_data`  in  `word`  load result.
- `issue_valid`  in  1  a load is issued this cycle.
- `issue_rd`  in  `regnum`  destination of the issued load.
- `busy`  out  `RegisterCount`  scoreboard; bit i = load to xi outstanding; bit 0 always 0.
- `write`  out  `word`  to register set.
- `write_reg`  out  `regnum`  to register set.
- `write_enable`  out  1  to register set.

## Operation
- At most one register write per cycle. Default priority: ALU over FIFO head.
- Forced mode: `alu_stall` high → FIFO head selected unconditionally. `alu_valid` in this mode is a protocol violation; the ALU result is dropped and an assertion fires.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the ALU wins.
  - Clears when the FIFO head is written or the FIFO is empty.
  - `alu_stall` is set at the edge where the counter reaches `StarveLimit`. It clears after the forced write.
- FIFO:
  - Accepted memory results are written at the tail; the head is eligible from the cycle after acceptance. There is no bypass.
  - `mem_ready = !full`, derived from registered occupancy only and never from `mem_valid`.
  - Simultaneous push and pop with the FIFO full is not allowed, because ready is low. Simultaneous push and pop at other occupancies keeps the count unchanged.
  - Pointers wrap modulo `FifoDepth`.
- x0 handling: a selected result with rd==0 is consumed, but `write_enable` stays 0. rd==0 never sets or clears `busy`.
- Scoreboard:
  - `issue_valid` with `issue_rd != 0` sets the busy bit at the next edge.
  - A FIFO-head write clears the busy bit of its rd at the same edge the write is registered.
  - Same-edge set and clear of one register: set wins.
  - Issuing to an already-busy register is a protocol violation (assertion). Upstream stalls on `busy`.
  - An ALU write does not touch `busy`.
- Reset (`res` low, any time, including mid-transfer):
  - FIFO emptied, scoreboard cleared, starve counter 0.
  - `write_enable`, `write`, `write_reg`, `alu_stall` all 0.
  - `mem_ready` is forced 0 while `res` is low and is 1 from the first cycle after release.

## Timing
- Write outputs are registered.
- ALU result at cycle N → `write_enable` asserted in cycle N+1.
- Memory result accepted at edge N, FIFO previously empty, no ALU result at N+1 → write in N+2.
- `busy` is visible one cycle after the `issue_valid` cycle. It drops in the same cycle `write_enable` shows the load result.
- Worst case memory wait with a continuously busy ALU is `StarveLimit` + 1 cycles behind the head.

## Structure
- `word` and `regnum` come from `definitions.svh`.
- Add `WB_FIFO_DEPTH` and `WB_STARVE_LIMIT` default defines there.
- One sub-module: `wb_fifo` (parameterised sync FIFO of {`regnum`, `word`}, with push, pop, full, empty and async active-low reset).
- Arbitration, starve counter and scoreboard live in `wb_arbiter`.

## Test plan
- **ALU only:** `alu_valid`, rd=5, data 0x1234 at cycle 3 → `write_enable`=1, `write_reg`=5, `write`=0x1234 in cycle 4; `busy`=0.
- **Load lifecycle:**
  - `issue_rd`=7 at cycle 1 → `busy[7]`=1 from cycle 2.
  - Memory result rd=7, 0xDEAD accepted at cycle 5 → write in cycle 7; `busy[7]`=0 in cycle 7.
- **Backpressure:** push 2 memory results with no pop (ALU valid every cycle) → `mem_ready`=0 after the 2nd acceptance; a third `mem_valid` is held off and no data is lost.
- **Starvation:** FIFO non-empty, ALU valid every cycle, `StarveLimit`=4 → `alu_stall`=1 after 4 lost cycles, FIFO head written next, then `alu_stall`=0.
- **x0 and collision:**
  - ALU rd=0 → no `write_enable`.
  - `issue_rd`=9 in the same cycle a rd=9 FIFO write commits → `busy[9]` stays 1.
- **Mid-operation reset:** `res` low with FIFO holding 2 entries and `busy[3]`=1 → all outputs 0 immediately; after release `mem_ready`=1, FIFO empty, no stale writes.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types and default sizing for the writeback path of the RV core.
// Provides the architectural word/register-number types, the FIFO entry
// layout and default parameter values used by wb_arbiter and wb_fifo.
package wb_arbiter_pkg;

  localparam int REGISTER_COUNT  = 32;
  localparam int WB_FIFO_DEPTH   = 2;
  localparam int WB_STARVE_LIMIT = 4;

  localparam int WORD_BITS = 32;
  localparam int REG_BITS  = $clog2(REGISTER_COUNT);

  typedef logic [WORD_BITS-1:0] word;
  typedef logic [REG_BITS-1:0]  regnum;

  // One buffered memory result: destination register plus load data.
  typedef struct packed {
    regnum rd;
    word   data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering memory results ahead of the register write port.
// Latency: head visible the cycle after a push; no bypass. Backpressure: full
// blocks push, empty blocks pop; both flags come from registered occupancy.
// Ports: clk, res (async active-low), push/din, pop/dout, full, empty.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int Depth = WB_FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      res,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PtrBits = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntBits = $clog2(Depth + 1);
  localparam logic [CntBits-1:0] CountMax = CntBits'(Depth);

  wb_entry_t          mem [Depth];
  logic [PtrBits-1:0] wr_ptr;
  logic [PtrBits-1:0] rd_ptr;
  logic [CntBits-1:0] count;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CountMax);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Depth is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PtrBits'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PtrBits'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CntBits'(1);
        2'b01:   count <= count - CntBits'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and buffered memory results onto the
// single register write port, and tracks outstanding load destinations.
// Latency: ALU result -> write 1 cycle; accepted memory result -> write >= 2.
// Backpressure: mem_ready = !full; alu_stall forces the FIFO head through.
// Ports: clk/res; alu_valid/alu_rd/alu_data/alu_stall; mem_valid/mem_ready/
// mem_rd/mem_data; issue_valid/issue_rd; busy; write/write_reg/write_enable.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int RegisterCount = REGISTER_COUNT,
  parameter int FifoDepth     = WB_FIFO_DEPTH,
  parameter int StarveLimit   = WB_STARVE_LIMIT
) (
  input  logic                     clk,
  input  logic                     res,
  input  logic                     alu_valid,
  input  regnum                    alu_rd,
  input  word                      alu_data,
  output logic                     alu_stall,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  regnum                    mem_rd,
  input  word                      mem_data,
  input  logic                     issue_valid,
  input  regnum                    issue_rd,
  output logic [RegisterCount-1:0] busy,
  output word                      write,
  output regnum                    write_reg,
  output logic                     write_enable
);

  localparam int SW = $clog2(StarveLimit + 1);
  localparam logic [SW-1:0] StarveMax = SW'(StarveLimit);

  wb_entry_t              head;
  wb_entry_t              fifo_in;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   sel_alu;
  logic                   sel_fifo;
  logic [SW-1:0]          starve_cnt;
  logic [SW-1:0]          starve_next;
  logic [RegisterCount-1:0] set_mask;
  logic [RegisterCount-1:0] clr_mask;
  logic [RegisterCount-1:0] busy_next;

  // Ready is held low throughout reset so nothing is accepted into a FIFO
  // that is being cleared.
  assign mem_ready    = res && !fifo_full;
  assign push         = mem_valid && mem_ready;
  assign fifo_in.rd   = mem_rd;
  assign fifo_in.data = mem_data;

  wb_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk  (clk),
    .res  (res),
    .push (push),
    .pop  (sel_fifo),
    .din  (fifo_in),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // ALU normally wins; while stalled the head goes through and any ALU
  // result presented anyway is dropped.
  always_comb begin
    sel_alu  = 1'b0;
    sel_fifo = 1'b0;
    if (alu_stall) begin
      sel_fifo = !fifo_empty;
    end else if (alu_valid) begin
      sel_alu = 1'b1;
    end else begin
      sel_fifo = !fifo_empty;
    end
  end

  // Counts cycles the waiting head lost to the ALU; saturates at the limit.
  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || sel_fifo) begin
      starve_next = '0;
    end else if (sel_alu && starve_cnt != StarveMax) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Set wins over clear on the same register; x0 is never tracked.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (issue_valid && issue_rd != '0) set_mask = RegisterCount'(1) << issue_rd;
    if (sel_fifo && head.rd != '0)     clr_mask = RegisterCount'(1) << head.rd;
    busy_next = ((busy & ~clr_mask) | set_mask) & ~RegisterCount'(1);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
      busy       <= '0;
    end else begin
      starve_cnt <= starve_next;
      alu_stall  <= (starve_next == StarveMax);
      busy       <= busy_next;
    end
  end

  // A selected rd==0 result is consumed but never written.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      write_enable <= 1'b0;
      write_reg    <= '0;
      write        <= '0;
    end else if (sel_alu) begin
      write_enable <= (alu_rd != '0);
      write_reg    <= alu_rd;
      write        <= alu_data;
    end else if (sel_fifo) begin
      write_enable <= (head.rd != '0);
      write_reg    <= head.rd;
      write        <= head.data;
    end else begin
      write_enable <= 1'b0;
    end
  end

  a_no_alu_during_stall : assert property (
    @(posedge clk) disable iff (!res) !(alu_valid && alu_stall));

  // Re-issuing is legal only when the same edge retires the old load.
  a_no_issue_to_busy : assert property (
    @(posedge clk) disable iff (!res)
    !(issue_valid && issue_rd != '0 && busy[issue_rd] && !clr_mask[issue_rd]));

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic        clk;
  logic        res;
  logic        alu_valid;
  regnum       alu_rd;
  word         alu_data;
  logic        alu_stall;
  logic        mem_valid;
  logic        mem_ready;
  regnum       mem_rd;
  word         mem_data;
  logic        issue_valid;
  regnum       issue_rd;
  logic [31:0] busy;
  word         write;
  regnum       write_reg;
  logic        write_enable;

  int checks;
  int failures;

  wb_arbiter #(
    .RegisterCount(32),
    .FifoDepth(2),
    .StarveLimit(4)
  ) dut (
    .clk(clk), .res(res),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_stall(alu_stall),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .busy(busy),
    .write(write), .write_reg(write_reg), .write_enable(write_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; outputs are then read 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    issue_valid = 0; issue_rd = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    res = 0;
    tick(); tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b want=0", write_enable); end
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL reset_mem_ready got=%b want=0", mem_ready); end
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL reset_busy got=%h want=0", busy); end
    checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", alu_stall); end
    res = 1;
    tick();
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL release_mem_ready got=%b want=1", mem_ready); end
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 32'h1234;
    tick();
    alu_valid = 0;
    checks++; if (write_enable !== 1'b1) begin failures++; $display("FAIL alu_we got=%b want=1", write_enable); end
    checks++; if (write_reg !== 5'd5) begin failures++; $display("FAIL alu_reg got=%0d want=5", write_reg); end
    checks++; if (write !== 32'h1234) begin failures++; $display("FAIL alu_data got=%h want=1234", write); end
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL alu_busy got=%h want=0", busy); end
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL alu_we_drop got=%b want=0", write_enable); end
  endtask

  task automatic test_load_lifecycle();
    issue_valid = 1; issue_rd = 5'd7;
    tick();
    issue_valid = 0;
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL load_busy_set got=%h want=00000080", busy); end
    tick(); tick();
    mem_valid = 1; mem_rd = 5'd7; mem_data = 32'hDEAD;
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL load_ready got=%b want=1", mem_ready); end
    tick();
    mem_valid = 0;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL load_no_bypass got=%b want=0", write_enable); end
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL load_busy_hold got=%h want=00000080", busy); end
    tick();
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd7) begin failures++; $display("FAIL load_write we=%b reg=%0d want we=1 reg=7", write_enable, write_reg); end
    checks++; if (write !== 32'hDEAD) begin failures++; $display("FAIL load_data got=%h want=dead", write); end
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL load_busy_clr got=%h want=0", busy); end
    tick();
  endtask

  task automatic test_starvation();
    mem_valid = 1; mem_rd = 5'd20; mem_data = 32'h55;
    alu_valid = 1; alu_rd = 5'd2; alu_data = 32'h2;
    tick();
    mem_valid = 0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL starve_early_stall cyc=%0d got=%b want=0", k, alu_stall); end
      checks++; if (write_enable !== 1'b1 || write_reg !== 5'd2) begin failures++; $display("FAIL starve_alu_win cyc=%0d we=%b reg=%0d want we=1 reg=2", k, write_enable, write_reg); end
      tick();
    end
    checks++; if (alu_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%b want=1", alu_stall); end
    alu_valid = 0;
    tick();
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd20 || write !== 32'h55) begin
      failures++; $display("FAIL starve_forced we=%b reg=%0d data=%h want we=1 reg=20 data=55", write_enable, write_reg, write);
    end
    checks++; if (alu_stall !== 1'b0) begin failures++; $display("FAIL starve_stall_clr got=%b want=0", alu_stall); end
    tick();
  endtask

  task automatic test_backpressure();
    regnum bp_rd [3];
    word   bp_d  [3];
    regnum got_rd [$];
    word   got_d  [$];
    int    acc;
    bit    held;
    bit    fire;
    bp_rd = '{5'd10, 5'd11, 5'd12};
    bp_d  = '{32'hA0, 32'hA1, 32'hA2};
    acc = 0; held = 0;
    for (int c = 0; c < 26; c++) begin
      alu_valid = (c < 16) && !alu_stall; alu_rd = 5'd1; alu_data = c;
      mem_valid = (acc < 3);
      if (acc < 3) begin mem_rd = bp_rd[acc]; mem_data = bp_d[acc]; end
      fire = mem_valid && mem_ready;
      if (mem_valid && !mem_ready) held = 1;
      tick();
      if (fire) begin
        acc++;
        if (acc == 2) begin
          checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%b want=0", mem_ready); end
        end
      end
      if (write_enable && write_reg != 5'd1) begin
        got_rd.push_back(write_reg);
        got_d.push_back(write);
      end
    end
    idle_inputs();
    checks++; if (!held) begin failures++; $display("FAIL bp_held_off got=0 want=1"); end
    checks++; if (acc !== 3) begin failures++; $display("FAIL bp_accepted got=%0d want=3", acc); end
    checks++; if (got_rd.size() !== 3) begin failures++; $display("FAIL bp_writes got=%0d want=3", got_rd.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < got_rd.size()) begin
        checks++; if (got_rd[i] !== bp_rd[i] || got_d[i] !== bp_d[i]) begin
          failures++; $display("FAIL bp_order idx=%0d got=%0d/%h want=%0d/%h", i, got_rd[i], got_d[i], bp_rd[i], bp_d[i]);
        end
      end
    end
  endtask

  task automatic test_x0_collision();
    alu_valid = 1; alu_rd = 5'd0; alu_data = 32'hFF;
    tick();
    alu_valid = 0;
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL x0_alu_we got=%b want=0", write_enable); end
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    issue_valid = 0;
    checks++; if (busy !== 32'h0) begin failures++; $display("FAIL x0_issue_busy got=%h want=0", busy); end
    mem_valid = 1; mem_rd = 5'd0; mem_data = 32'h77;
    tick();
    mem_valid = 0;
    tick();
    checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL x0_mem_we got=%b want=0", write_enable); end
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    checks++; if (busy !== 32'h0000_0200) begin failures++; $display("FAIL col_busy_set got=%h want=00000200", busy); end
    mem_valid = 1; mem_rd = 5'd9; mem_data = 32'h99;
    tick();
    mem_valid = 0;
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    checks++; if (write_enable !== 1'b1 || write_reg !== 5'd9) begin failures++; $display("FAIL col_write we=%b reg=%0d want we=1 reg=9", write_enable, write_reg); end
    checks++; if (busy !== 32'h0000_0200) begin failures++; $display("FAIL col_set_wins got=%h want=00000200", busy); end
  endtask

  task automatic test_reset_mid();
    res = 0; tick(); res = 1; tick();
    issue_valid = 1; issue_rd = 5'd3;
    alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h11;
    tick();
    issue_valid = 0;
    mem_valid = 1; mem_rd = 5'd4; mem_data = 32'h44;
    tick();
    mem_rd = 5'd5; mem_data = 32'h55;
    tick();
    mem_valid = 0;
    checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL mid_full got=%b want=0", mem_ready); end
    checks++; if (busy !== 32'h0000_0008) begin failures++; $display("FAIL mid_busy got=%h want=00000008", busy); end
    alu_valid = 0;
    res = 0;
    #1;
    checks++; if (write_enable !== 1'b0 || write !== 32'h0 || write_reg !== 5'd0) begin
      failures++; $display("FAIL mid_rst_write we=%b data=%h reg=%0d want 0", write_enable, write, write_reg);
    end
    checks++; if (busy !== 32'h0 || alu_stall !== 1'b0 || mem_ready !== 1'b0) begin
      failures++; $display("FAIL mid_rst_state busy=%h stall=%b ready=%b want 0", busy, alu_stall, mem_ready);
    end
    tick();
    res = 1;
    tick();
    checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b want=1", mem_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (write_enable !== 1'b0) begin failures++; $display("FAIL mid_stale cyc=%0d got=%b want=0", k, write_enable); end
      tick();
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();
    res = 0;
    #1;
    test_reset();
    test_alu_only();
    test_load_lifecycle();
    test_starvation();
    test_backpressure();
    test_x0_collision();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
